ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_port_arbiter_if.sv | 54 +++++
 rtl/ram_rd_return.sv | 48 ++++
 rtl/ram_port_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared defaults, FSM state encoding and read-return tag type for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKED_0 = 2'd1,
    LOCKED_1 = 2'd2
  } arb_state_e;

  // One stage of the read owner pipeline: a read is in flight and who issued it.
  typedef struct packed {
    logic vld;
    logic own;
  } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Two-requester RAM access bus plus the RAM command/return side.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              lock0;
  logic              wr0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              lock1;
  logic              wr1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              ram_cs;
  logic              ram_wr;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  // Requester side; also supplies the RAM read data.
  modport master (
    output req0, lock0, wr0, addr0, wdata0,
    output req1, lock1, wr1, addr1, wdata1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_cs, ram_wr, ram_rd, ram_addr, ram_data_in,
    output ram_data_out
  );

  // Arbiter side.
  modport slave (
    input  req0, lock0, wr0, addr0, wdata0,
    input  req1, lock1, wr1, addr1, wdata1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_cs, ram_wr, ram_rd, ram_addr, ram_data_in,
    input  ram_data_out
  );

endinterface

// File: rtl/ram_rd_return.sv
// Tracks which requester owns each in-flight read and steers RAM data back to it.
module ram_rd_return
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_xfer,
  input  logic              rd_own,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  rd_tag_t tag1_q;
  rd_tag_t tag2_q;

  // Stage 1 aligns with the RAM strobe, stage 2 with the RAM sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      tag1_q.vld <= rd_xfer;
      tag1_q.own <= rd_own;
      tag2_q     <= tag1_q;
    end
  end

  // Capture RAM data into the owner's register and pulse its rvalid for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= tag2_q.vld & ~tag2_q.own;
      rvalid1 <= tag2_q.vld & tag2_q.own;
      if (tag2_q.vld && !tag2_q.own) rdata0 <= ram_data_out;
      if (tag2_q.vld && tag2_q.own)  rdata1 <= ram_data_out;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with ownership lock sharing one synchronous RAM between two requesters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              ptr_q;
  logic              ptr_d;
  logic              gnt0_c;
  logic              gnt1_c;
  logic              xfer_c;
  logic              wr_sel_c;
  logic [ADDR_W-1:0] addr_sel_c;
  logic [DATA_W-1:0] wdata_sel_c;

  logic              ram_cs_q;
  logic              ram_wr_q;
  logic              ram_rd_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_in_q;

  // Grant decision and next state; no grant is ever issued while in reset.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.req0 && (!bus.req1 || !ptr_q)) begin
            gnt0_c = 1'b1;
            ptr_d  = 1'b1;
            if (bus.lock0) state_d = LOCKED_0;
          end else if (bus.req1) begin
            gnt1_c = 1'b1;
            ptr_d  = 1'b0;
            if (bus.lock1) state_d = LOCKED_1;
          end
        end
        LOCKED_0: begin
          gnt0_c = bus.req0;
          if (!bus.req0 || !bus.lock0) state_d = IDLE;
        end
        LOCKED_1: begin
          gnt1_c = bus.req1;
          if (!bus.req1 || !bus.lock1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Arbitration state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign xfer_c      = gnt0_c | gnt1_c;
  assign wr_sel_c    = gnt1_c ? bus.wr1    : bus.wr0;
  assign addr_sel_c  = gnt1_c ? bus.addr1  : bus.addr0;
  assign wdata_sel_c = gnt1_c ? bus.wdata1 : bus.wdata0;

  // RAM command register: strobes for one cycle per transfer, address/data held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cs_q      <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
    end else begin
      ram_cs_q <= xfer_c;
      ram_wr_q <= xfer_c & wr_sel_c;
      ram_rd_q <= xfer_c & ~wr_sel_c;
      if (xfer_c) begin
        ram_addr_q    <= addr_sel_c;
        ram_data_in_q <= wdata_sel_c;
      end
    end
  end

  // Read data return path.
  ram_rd_return #(
    .DATA_W(DATA_W)
  ) u_rd_return (
    .clk         (clk),
    .rst         (rst),
    .rd_xfer     (xfer_c & ~wr_sel_c),
    .rd_own      (gnt1_c),
    .ram_data_out(bus.ram_data_out),
    .rvalid0     (bus.rvalid0),
    .rvalid1     (bus.rvalid1),
    .rdata0      (bus.rdata0),
    .rdata1      (bus.rdata1)
  );

  assign bus.gnt0        = gnt0_c;
  assign bus.gnt1        = gnt1_c;
  assign bus.ram_cs      = ram_cs_q;
  assign bus.ram_wr      = ram_wr_q;
  assign bus.ram_rd      = ram_rd_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_data_in = ram_data_in_q;

endmodule
